// File: rtl/glitc_ps_pkg.sv
// Shared encodings for the GLITC MMCM dynamic phase-shift sequencer.
package glitc_ps_pkg;
  localparam int PERIOD_STEPS_DEF = 224;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENABLE  = 3'd1,
    ST_WAITING = 3'd2,
    ST_DONE    = 3'd3,
    ST_FAULT   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    STATUS_OK          = 2'd0,
    STATUS_ABORTED     = 2'd1,
    STATUS_TIMEOUT     = 2'd2,
    STATUS_BAD_CHANNEL = 2'd3
  } status_e;
endpackage

// File: rtl/glitc_ps_position_tracker.sv
// Per-MMCM phase position modulo PERIOD_STEPS, plus shortest-path distance home.
module glitc_ps_position_tracker
  import glitc_ps_pkg::*;
#(
  parameter int PERIOD_STEPS = PERIOD_STEPS_DEF,
  parameter int POS_BITS     = 8,
  parameter int STEP_BITS    = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 step_i,
  input  logic                 inc_i,
  output logic [POS_BITS-1:0]  position_o,
  output logic [STEP_BITS-1:0] home_steps_o,
  output logic                 home_inc_o
);
  logic [POS_BITS-1:0] pos_q, pos_d;

  always_comb begin
    pos_d = pos_q;
    if (step_i) begin
      if (inc_i) pos_d = (pos_q == POS_BITS'(PERIOD_STEPS-1)) ? '0 : pos_q + 1'b1;
      else       pos_d = (pos_q == '0) ? POS_BITS'(PERIOD_STEPS-1) : pos_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) pos_q <= '0;
    else          pos_q <= pos_d;
  end

  // Exactly half a period goes the decrement way.
  assign home_inc_o   = (int'(pos_q) > PERIOD_STEPS/2);
  assign home_steps_o = home_inc_o ? STEP_BITS'(PERIOD_STEPS - int'(pos_q)) : STEP_BITS'(pos_q);
  assign position_o   = pos_q;
endmodule

// File: rtl/glitc_phase_shift_sequencer.sv
// Single sequencer driving PSEN/PSINCDEC of NUM_CHANNELS MMCMs, one channel at a time.
module glitc_phase_shift_sequencer
  import glitc_ps_pkg::*;
#(
  parameter int NUM_CHANNELS   = 2,
  parameter int STEP_BITS      = 8,
  parameter int PERIOD_STEPS   = PERIOD_STEPS_DEF,
  parameter int POS_BITS       = 8,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CH_BITS        = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic                             req_i,
  input  logic [CH_BITS-1:0]               req_channel_i,
  input  logic [STEP_BITS-1:0]             req_steps_i,
  input  logic                             req_increment_ndecrement_i,
  input  logic                             req_home_i,
  input  logic                             abort_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [1:0]                       status_o,
  output logic [NUM_CHANNELS-1:0]          ps_en_o,
  output logic                             ps_increment_ndecrement_o,
  input  logic [NUM_CHANNELS-1:0]          ps_done_i,
  output logic [NUM_CHANNELS*POS_BITS-1:0] position_o
);
  localparam int TMO_BITS = $clog2(TIMEOUT_CYCLES + 1);

  state_e                 state_q, state_d;
  status_e                status_q, status_d;
  logic [CH_BITS-1:0]     ch_q, ch_d;
  logic                   inc_q, inc_d;
  logic [STEP_BITS-1:0]   target_q, target_d, cnt_q, cnt_d;
  logic [TMO_BITS-1:0]    tmo_q, tmo_d;
  logic                   abort_q, abort_d;

  logic [NUM_CHANNELS-1:0]                sel_vec, step;
  logic [NUM_CHANNELS-1:0][POS_BITS-1:0]  pos;
  logic [NUM_CHANNELS-1:0][STEP_BITS-1:0] home_steps;
  logic [NUM_CHANNELS-1:0]                home_inc;
  logic                                   sel_done, req_ok, req_home_inc;
  logic [STEP_BITS-1:0]                   req_home_steps, req_target;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    assign sel_vec[c] = (ch_q == CH_BITS'(c));
    assign step[c]    = (state_q == ST_WAITING) && sel_vec[c] && ps_done_i[c];
    assign ps_en_o[c] = (state_q == ST_ENABLE) && sel_vec[c];

    glitc_ps_position_tracker #(
      .PERIOD_STEPS(PERIOD_STEPS), .POS_BITS(POS_BITS), .STEP_BITS(STEP_BITS)
    ) u_trk (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .step_i       (step[c]),
      .inc_i        (inc_q),
      .position_o   (pos[c]),
      .home_steps_o (home_steps[c]),
      .home_inc_o   (home_inc[c])
    );
  end

  assign sel_done   = |step;
  assign position_o = pos;

  // Home distance of the requested channel; out-of-range channels leave zero.
  always_comb begin
    req_home_steps = '0;
    req_home_inc   = 1'b0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (req_channel_i == CH_BITS'(c)) begin
        req_home_steps = home_steps[c];
        req_home_inc   = home_inc[c];
      end
    end
  end

  assign req_ok     = (int'(req_channel_i) < NUM_CHANNELS);
  assign req_target = req_home_i ? req_home_steps : req_steps_i;

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    ch_d     = ch_q;
    inc_d    = inc_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    abort_d  = abort_q | ((state_q != ST_IDLE) & abort_i);
    unique case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (req_i) begin
          ch_d     = req_channel_i;
          inc_d    = req_home_i ? req_home_inc : req_increment_ndecrement_i;
          target_d = req_target;
          cnt_d    = '0;
          status_d = STATUS_OK;
          if (!req_ok) begin
            status_d = STATUS_BAD_CHANNEL;
            state_d  = ST_DONE;
          end else if (req_target == '0) begin
            state_d  = ST_DONE;
          end else begin
            state_d  = ST_ENABLE;
          end
        end
      end
      ST_ENABLE: begin
        tmo_d   = '0;
        state_d = ST_WAITING;
      end
      ST_WAITING: begin
        if (sel_done) begin
          cnt_d = cnt_q + 1'b1;
          // Reaching the target wins over an abort in the same cycle.
          if (cnt_d == target_q) begin
            status_d = STATUS_OK;
            state_d  = ST_DONE;
          end else if (abort_q || abort_i) begin
            status_d = STATUS_ABORTED;
            state_d  = ST_DONE;
          end else begin
            state_d  = ST_ENABLE;
          end
        end else if (tmo_q == TMO_BITS'(TIMEOUT_CYCLES - 1)) begin
          status_d = STATUS_TIMEOUT;
          state_d  = ST_FAULT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_DONE, ST_FAULT: state_d = ST_IDLE;
      default:           state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      status_q <= STATUS_OK;
      ch_q     <= '0;
      inc_q    <= 1'b0;
      target_q <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      ch_q     <= ch_d;
      inc_q    <= inc_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      abort_q  <= abort_d;
    end
  end

  assign busy_o                    = (state_q != ST_IDLE);
  assign done_o                    = (state_q == ST_DONE) || (state_q == ST_FAULT);
  assign status_o                  = done_o ? status_q : STATUS_OK;
  assign ps_increment_ndecrement_o = inc_q;
endmodule
